// File: rtl/ntt_adder_ctrl.sv
// NTT/INTT butterfly sequencer: walks every stage of a Kyber or Dilithium
// transform, issuing one coefficient-pair read per cycle and replaying the
// read addresses as write-back addresses LAT cycles later.
module ntt_adder_ctrl #(
    parameter int LAT  = 8,
    parameter int NLOG = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kd_mode,
    input  logic            inv,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [NLOG-1:0] rd_addr_a,
    output logic [NLOG-1:0] rd_addr_b,
    output logic [NLOG-1:0] tw_idx,
    output logic            wr_en,
    output logic [NLOG-1:0] wr_addr_a,
    output logic [NLOG-1:0] wr_addr_b,
    output logic            adder_mode,
    output logic [1:0]      sel_a
);

    localparam int HALF = 1 << (NLOG - 1);
    localparam int IW   = NLOG - 1;
    localparam int SW   = $clog2(NLOG + 1);
    localparam int DW   = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [IW-1:0] I_LAST   = IW'(HALF - 1);
    localparam logic [DW-1:0] D_LAST   = DW'(LAT - 1);
    localparam logic [SW-1:0] S_LAST_K = SW'(NLOG - 2);
    localparam logic [SW-1:0] S_LAST_D = SW'(NLOG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q;
    logic [DW-1:0]   dcnt_q;
    logic [SW-1:0]   stg_q;
    logic            kd_q, inv_q;
    logic            last_stage;

    logic [SW-1:0]   ll;
    logic [NLOG-1:0] iw, len, grp, g, j, addr_a;

    logic [LAT-1:0]  vld_p;
    logic [NLOG-1:0] wa_p [LAT];
    logic [NLOG-1:0] wb_p [LAT];

    assign last_stage = (stg_q == (kd_q ? S_LAST_D : S_LAST_K));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: RUN for one stage, DRAIN the pipeline, repeat, then DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (i_q == I_LAST) state_d = DRAIN;
            DRAIN:   if (dcnt_q == D_LAST) state_d = last_stage ? DONE : RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Butterfly, drain and stage counters plus the modes latched at start
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q    <= '0;
            dcnt_q <= '0;
            stg_q  <= '0;
            kd_q   <= 1'b0;
            inv_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    i_q    <= '0;
                    dcnt_q <= '0;
                    stg_q  <= '0;
                    if (start) begin
                        kd_q  <= kd_mode;
                        inv_q <= inv;
                    end
                end
                RUN:   i_q <= i_q + 1'b1;
                DRAIN: begin
                    if (dcnt_q == D_LAST) begin
                        dcnt_q <= '0;
                        stg_q  <= stg_q + 1'b1;
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read address / twiddle generation; ll is log2 of the current span
    always_comb begin
        ll        = inv_q ? (stg_q + (kd_q ? SW'(0) : SW'(1))) : (S_LAST_D - stg_q);
        iw        = {1'b0, i_q};
        len       = NLOG'(1) << ll;
        grp       = NLOG'(HALF) >> ll;
        g         = iw >> ll;
        j         = iw & (len - NLOG'(1));
        addr_a    = (g << (ll + SW'(1))) | j;
        rd_en     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_idx    = '0;
        if (state_q == RUN) begin
            rd_en     = 1'b1;
            rd_addr_a = addr_a;
            rd_addr_b = addr_a + len;
            tw_idx    = inv_q ? ((grp << 1) - NLOG'(1) - g) : (grp + g);
        end
    end

    // Write-back pipeline: read strobe and addresses delayed by LAT cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            for (int k = 0; k < LAT; k++) begin
                wa_p[k] <= '0;
                wb_p[k] <= '0;
            end
        end else begin
            vld_p[0] <= rd_en;
            wa_p[0]  <= rd_addr_a;
            wb_p[0]  <= rd_addr_b;
            for (int k = 1; k < LAT; k++) begin
                vld_p[k] <= vld_p[k-1];
                wa_p[k]  <= wa_p[k-1];
                wb_p[k]  <= wb_p[k-1];
            end
        end
    end

    assign wr_en      = vld_p[LAT-1];
    assign wr_addr_a  = wa_p[LAT-1];
    assign wr_addr_b  = wb_p[LAT-1];
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign adder_mode = busy & kd_q;
    assign sel_a      = (busy && !kd_q && inv_q) ? 2'b10 : 2'b00;

endmodule

// File: doc/ntt_adder_ctrl.md
NTT_ADDER_CTRL -- requirements
Module: ntt_adder_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 8: read-issue to write-back latency, in cycles, of the butterfly/adder pipeline.
REQ-002 SHALL have parameter NLOG, default 8: log2 of polynomial length (256 coefficients, 128 butterflies per stage).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: start request, sampled only in IDLE.
REQ-006 SHALL have port kd_mode, input, 1: 0 selects Kyber (7 stages), 1 selects Dilithium (8 stages); sampled with start.
REQ-007 SHALL have port inv, input, 1: 0 selects forward NTT, 1 selects INTT; sampled with start.
REQ-008 SHALL have port busy, output, 1: high from the cycle after start is accepted until done is asserted, inclusive of done.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rd_en, output, 1: coefficient-pair read strobe.
REQ-011 SHALL have ports rd_addr_a and rd_addr_b, output, 8 each: butterfly operand addresses.
REQ-012 SHALL have port tw_idx, output, 8: twiddle ROM index, aligned with rd_en.
REQ-013 SHALL have port wr_en, output, 1: write-back strobe.
REQ-014 SHALL have ports wr_addr_a and wr_addr_b, output, 8 each: write-back addresses.
REQ-015 SHALL have port adder_mode, output, 1: Adder_0_mode drive; equals latched kd_mode.
REQ-016 SHALL have port sel_a, output, 2: adder operand-alignment select; 2'b10 when latched kd_mode=0 and inv=1, else 2'b00.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE->RUN SHALL occur when start=1; kd_mode and inv are latched at that edge; start in any other state is ignored.
REQ-019 RUN SHALL issue one butterfly per cycle (rd_en=1) using counter i=0..127, for exactly 128 cycles per stage, without bubbles.
REQ-020 Stage span len SHALL be: NTT, 128 down to 2 (Kyber) or to 1 (Dilithium), halving per stage; INTT, 2 (Kyber) or 1 (Dilithium) up to 128, doubling per stage.
REQ-021 With g=i/len, j=i%len, G=128/len: rd_addr_a SHALL be 2*len*g+j and rd_addr_b SHALL be rd_addr_a+len.
REQ-022 tw_idx SHALL be G+g for NTT and 2G-1-g for INTT; ranges: Kyber NTT 1..127, Dilithium NTT 1..255.
REQ-023 After i=127, RUN->DRAIN SHALL occur; DRAIN lasts exactly LAT cycles with rd_en=0, so the next stage never reads an address before it has been written back.
REQ-024 DRAIN->RUN SHALL occur for the next stage; after the final stage, DRAIN->DONE.
REQ-025 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-026 wr_en, wr_addr_a and wr_addr_b SHALL equal rd_en, rd_addr_a and rd_addr_b delayed exactly LAT cycles through a shift pipeline.
REQ-027 Timing SHALL be: start sampled at cycle 0, first rd_en at cycle 1, done at cycle S*(128+LAT)+1, where S is the stage count.
REQ-028 adder_mode and sel_a SHALL remain constant from the first RUN cycle through DONE, and SHALL be 0 in IDLE.
REQ-029 In IDLE, rd_en=0, all addresses are 0, and tw_idx=0.

Reset
REQ-030 rst=1 at any edge, including mid-RUN or mid-DRAIN, SHALL force IDLE and clear all counters, latched modes and the write pipeline.
REQ-031 During and after reset, every output SHALL be 0; no wr_en pulse from a pre-reset read may appear.
REQ-032 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-033 Kyber NTT, LAT=8 -> first-cycle addrs (0,128), tw 1; stage-2 first addrs (0,64), tw 2; last-stage final read (253,255), tw 127; done at cycle 953.
REQ-034 Dilithium INTT -> first addrs (0,1), tw 255; second (2,3), tw 254; final stage addrs (127,255), tw 1; sel_a=00, adder_mode=1; done at cycle 1089.
REQ-035 Kyber INTT -> sel_a=2'b10 throughout busy; each wr_en/wr_addr matches the rd stream 8 cycles later; zero rd_en during every 8-cycle DRAIN.
REQ-036 rst at cycle 300 of a Kyber NTT -> next cycle all outputs 0, no residual wr_en; a new start after that runs the full sequence correctly.
REQ-037 start pulsed repeatedly while busy -> ignored, single done pulse; start held high at done -> new run begins the cycle after returning to IDLE.
